// File: rtl/seg_scan_driver_if.sv
// Display-side bus of the segment scanner: BCD digits and display options in,
// pin-level segment/anode drive and the frame strobe out.
interface seg_scan_driver_if;
  logic [3:0] Dig0;
  logic [3:0] Dig1;
  logic [3:0] Dig2;
  logic [3:0] Dig3;
  logic       Blank_lz;
  logic [3:0] Dp_mask;
  logic [6:0] Seg;
  logic       Dp;
  logic [3:0] An;
  logic       Frame;

  modport master (
    output Dig0, Dig1, Dig2, Dig3, Blank_lz, Dp_mask,
    input  Seg, Dp, An, Frame
  );

  modport slave (
    input  Dig0, Dig1, Dig2, Dig3, Blank_lz, Dp_mask,
    output Seg, Dp, An, Frame
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexes four BCD digits onto a common-anode 7-segment display with a
// per-frame input snapshot, leading-zero blanking and per-slot anti-ghost blanking.
//
//   state | meaning
//   SLOT0 | rightmost digit (Dig0) selected
//   SLOT1 | digit 1 selected
//   SLOT2 | digit 2 selected
//   SLOT3 | leftmost digit (Dig3) selected; its last cycle reloads the snapshot
module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic               Clock,
  input logic               Reset,
  seg_scan_driver_if.slave  bus
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_t;

  slot_t            slot;
  logic [DIV_W-1:0] div_cnt;
  logic             load_pend;
  logic [3:0]       snap_d0, snap_d1, snap_d2, snap_d3;
  logic [3:0]       snap_dp;
  logic             snap_lz;

  logic [6:0]       seg_q;
  logic             dp_q;
  logic [3:0]       an_q;
  logic             frame_q;

  logic [3:0]       cur_dig;
  logic             cur_blank;
  logic             cur_dp;
  logic [6:0]       seg_hi;
  logic [3:0]       an_hi;
  logic             lz3, lz2, lz1;
  logic             wrap;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h40;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Blanking chains from the left: a digit may only be blanked if every digit above it is
  assign lz3  = snap_lz && (snap_d3 == 4'd0);
  assign lz2  = lz3 && (snap_d2 == 4'd0);
  assign lz1  = lz2 && (snap_d1 == 4'd0);
  assign wrap = (div_cnt == DIV_LAST) && (slot == SLOT3);

  always_comb begin
    cur_dig   = snap_d0;
    cur_blank = 1'b0;
    cur_dp    = snap_dp[0];
    case (slot)
      SLOT0: begin cur_dig = snap_d0; cur_blank = 1'b0; cur_dp = snap_dp[0]; end
      SLOT1: begin cur_dig = snap_d1; cur_blank = lz1;  cur_dp = snap_dp[1]; end
      SLOT2: begin cur_dig = snap_d2; cur_blank = lz2;  cur_dp = snap_dp[2]; end
      SLOT3: begin cur_dig = snap_d3; cur_blank = lz3;  cur_dp = snap_dp[3]; end
      default: begin cur_dig = snap_d0; cur_blank = 1'b0; cur_dp = snap_dp[0]; end
    endcase
    seg_hi = cur_blank ? 7'h00 : decode(cur_dig);
    an_hi  = (div_cnt < BLANK_END) ? 4'b0000 : (4'b0001 << slot);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_cnt   <= '0;
      slot      <= SLOT0;
      load_pend <= 1'b1;
      snap_d0   <= '0;
      snap_d1   <= '0;
      snap_d2   <= '0;
      snap_d3   <= '0;
      snap_dp   <= '0;
      snap_lz   <= 1'b0;
      seg_q     <= {7{ACTIVE_LOW}};
      dp_q      <= ACTIVE_LOW;
      an_q      <= {4{ACTIVE_LOW}};
      frame_q   <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        case (slot)
          SLOT0:   slot <= SLOT1;
          SLOT1:   slot <= SLOT2;
          SLOT2:   slot <= SLOT3;
          default: slot <= SLOT0;
        endcase
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // load_pend gives a fresh snapshot on the first edge out of reset
      if (load_pend || wrap) begin
        snap_d0   <= bus.Dig0;
        snap_d1   <= bus.Dig1;
        snap_d2   <= bus.Dig2;
        snap_d3   <= bus.Dig3;
        snap_dp   <= bus.Dp_mask;
        snap_lz   <= bus.Blank_lz;
        load_pend <= 1'b0;
        frame_q   <= 1'b1;
      end else begin
        frame_q   <= 1'b0;
      end

      seg_q <= seg_hi ^ {7{ACTIVE_LOW}};
      dp_q  <= cur_dp ^ ACTIVE_LOW;
      an_q  <= an_hi ^ {4{ACTIVE_LOW}};
    end
  end

  assign bus.Seg   = seg_q;
  assign bus.Dp    = dp_q;
  assign bus.An    = an_q;
  assign bus.Frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4, BLANK_CYC=1, active-low pins.
module tb_seg_scan_driver;

  localparam logic [6:0] ZERO  = 7'b1000000;
  localparam logic [6:0] ONE   = 7'b1111001;
  localparam logic [6:0] TWO   = 7'b0100100;
  localparam logic [6:0] THREE = 7'b0110000;
  localparam logic [6:0] FIVE  = 7'b0010010;
  localparam logic [6:0] SIX   = 7'b0000010;
  localparam logic [6:0] NINE  = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] OFF   = 7'b1111111;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;
  int   ncyc;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .REFRESH_DIV(4),
    .BLANK_CYC  (1),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0b want=%0b", tag, ncyc, obs, exp);
    end
  endtask

  // One clock: outputs after edge ncyc reflect state position p = ncyc-1 of the frame.
  task automatic step(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [6:0] s3, input logic [3:0] dpm);
    int p;
    int sl;
    int d;
    logic [6:0] se;
    logic [3:0] ae;
    logic       de;
    @(posedge Clock);
    ncyc++;
    @(negedge Clock);
    p  = ncyc - 1;
    sl = (p / 4) % 4;
    d  = p % 4;
    ae = (d >= 1) ? ~(4'b0001 << sl) : 4'b1111;
    case (sl)
      0:       se = s0;
      1:       se = s1;
      2:       se = s2;
      default: se = s3;
    endcase
    de = ~dpm[sl];
    if (ncyc == 1) begin
      se = ZERO;
      de = 1'b1;
    end
    chk("an", 32'(bus.An), 32'(ae));
    chk("seg", 32'(bus.Seg), 32'(se));
    chk("dp", 32'(bus.Dp), 32'(de));
    chk("frame", 32'(bus.Frame), 32'((ncyc == 1) || (ncyc % 16 == 0)));
  endtask

  task automatic run(input int n, input logic [6:0] s0, input logic [6:0] s1,
                     input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpm);
    for (int i = 0; i < n; i++) step(s0, s1, s2, s3, dpm);
  endtask

  task automatic set_in(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                        input logic [3:0] d0, input logic lz, input logic [3:0] dpm);
    bus.Dig3     = d3;
    bus.Dig2     = d2;
    bus.Dig1     = d1;
    bus.Dig0     = d0;
    bus.Blank_lz = lz;
    bus.Dp_mask  = dpm;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ncyc   = 0;
    Reset  = 1'b1;
    set_in(4'd9, 4'd9, 4'd9, 4'd0, 1'b0, 4'b0000);
    repeat (2) @(negedge Clock);
    chk("rst_an", 32'(bus.An), 32'(4'b1111));
    chk("rst_seg", 32'(bus.Seg), 32'(OFF));
    chk("rst_dp", 32'(bus.Dp), 32'(1'b1));
    chk("rst_frame", 32'(bus.Frame), 32'(1'b0));
    Reset = 1'b0;

    // frame 0: 9,9,9,0 no blanking
    run(8, ZERO, NINE, NINE, NINE, 4'b0000);
    set_in(4'd0, 4'd0, 4'd5, 4'd0, 1'b1, 4'b0000);
    run(8, ZERO, NINE, NINE, NINE, 4'b0000);

    // frame 1: 0,0,5,0 with leading-zero blanking
    run(8, ZERO, FIVE, OFF, OFF, 4'b0000);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0000);
    run(8, ZERO, FIVE, OFF, OFF, 4'b0000);

    // frame 2: all zero, only digit 0 lit
    run(8, ZERO, OFF, OFF, OFF, 4'b0000);
    set_in(4'd3, 4'd2, 4'd1, 4'd5, 1'b0, 4'b0000);
    run(8, ZERO, OFF, OFF, OFF, 4'b0000);

    // frame 3: Dig0 5 -> 6 during slot 1 must not show until next frame
    run(6, FIVE, ONE, TWO, THREE, 4'b0000);
    bus.Dig0 = 4'd6;
    run(10, FIVE, ONE, TWO, THREE, 4'b0000);

    // frame 4: new Dig0 visible; queue dash code and a decimal point
    run(8, SIX, ONE, TWO, THREE, 4'b0000);
    set_in(4'd3, 4'd2, 4'b1100, 4'd6, 1'b0, 4'b0010);
    run(8, SIX, ONE, TWO, THREE, 4'b0000);

    // frame 5: dash on slot 1 and its decimal point
    run(16, SIX, DASH, TWO, THREE, 4'b0010);

    // frame 6: reset asynchronously while slot 2 anode is lit
    run(11, SIX, DASH, TWO, THREE, 4'b0010);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_an", 32'(bus.An), 32'(4'b1111));
    chk("mid_rst_seg", 32'(bus.Seg), 32'(OFF));
    chk("mid_rst_dp", 32'(bus.Dp), 32'(1'b1));
    chk("mid_rst_frame", 32'(bus.Frame), 32'(1'b0));
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    ncyc  = 0;

    // restart at slot 0 with a fresh snapshot
    run(16, SIX, DASH, TWO, THREE, 4'b0010);
    run(4, SIX, DASH, TWO, THREE, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the 4-digit BCD down-counter.
- Takes the four BCD digits and time-multiplexes them onto a common-anode 4-digit 7-segment display.
- Contains a refresh prescaler, a digit-slot scanner, a per-frame input snapshot, leading-zero blanking and anti-ghosting blank intervals.
- Outputs drive the board pins directly.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (minimum 2).
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off (must be less than REFRESH_DIV).
- ACTIVE_LOW, 1, 1 means Seg/Dp/An are active-low at the pins; 0 means active-high.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Dig0  in  4  rightmost digit (BCD).
- Dig1  in  4  digit 1.
- Dig2  in  4  digit 2.
- Dig3  in  4  leftmost digit.
- Blank_lz  in  1  1 enables leading-zero blanking.
- Dp_mask  in  4  decimal point enable per digit; bit i controls digit i.
- Seg  out  7  segments, Seg[0]=a … Seg[6]=g.
- Dp  out  1  decimal point.
- An  out  4  anode enables; An[i] selects digit i.
- Frame  out  1  one-cycle pulse when the snapshot reloads.

Behaviour:
- Interface: one clock, Clock; reset is asynchronous and active-high, Reset.
- Reset values (all inactive at pin polarity): An=1111, Seg=1111111, Dp=1, Frame=0 (for ACTIVE_LOW=1). Internal: div_cnt=0, slot=0, snapshot digits=0, snapshot Dp_mask=0, snapshot Blank_lz=0.
- Prescaler:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On the edge where div_cnt==REFRESH_DIV-1: div_cnt becomes 0 and slot advances 0→1→2→3→0.
- Snapshot:
  - On the edge where slot goes 3→0, and also on the first edge after reset release, register Dig0..Dig3, Dp_mask and Blank_lz.
  - Frame pulses high for exactly the cycle after that edge.
  - Input changes mid-frame never appear until the next frame.
- Leading-zero blanking (computed from the snapshot, only when the snapshot Blank_lz=1):
  - Digit3 blank if D3==0.
  - Digit2 blank if D3==0 and D2==0.
  - Digit1 blank if D3, D2 and D1 are all 0.
  - Digit0 never blanked.
- Blanked digit: segments all off; its Dp still follows Dp_mask.
- Decode, active-high before polarity (hex over g..a):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Codes 10–15 display a dash, 40 (g only).
- Anodes: while div_cnt < BLANK_CYC, all anodes off. Otherwise only An[slot] is active.
- Seg/Dp always show the current slot's digit, including during the blank interval.
- Output latency: Seg, Dp, An are registered, so each reflects (slot, div_cnt, snapshot) of the previous cycle. The first active anode appears at div_cnt==BLANK_CYC+1 of the slot, one cycle after the blank interval ends.
- Polarity: with ACTIVE_LOW=1, Seg, Dp and An are the bitwise inverse of active-high values. Frame is always active-high.
- Reset mid-scan: outputs go inactive immediately (asynchronous). After release the scan restarts at slot 0 with a fresh snapshot.
- No handshake: inputs are sampled only at snapshot edges and need no particular timing relative to the counter's clock, since both share Clock.

Test Plan:
(All with REFRESH_DIV=4, BLANK_CYC=1, ACTIVE_LOW=1.)
- Reset asserted mid-slot 2 → same cycle An=1111, Seg=1111111, Dp=1. Release → slot 0 restarts; Frame pulses once; first An=1110 two cycles into the slot.
- Dig3..0 = 9,9,9,0, Blank_lz=0 → over one 16-cycle frame, An cycles 1110/1101/1011/0111 with Seg 1000000 (0) / 0010000 (9) ×3. Each anode is active for 3 of 4 slot cycles.
- Dig3..0 = 0,0,5,0, Blank_lz=1 → digits 3 and 2 show Seg=1111111 while their anode is active; digit1 shows 0010010 (5); digit0 shows 1000000. With all four digits zero, only digit0 shows 1000000.
- Dig0 changed from 5 to 6 during slot 1 → slot 0 keeps 0010010 until after the 3→0 wrap, then shows 0000010. Frame is high for exactly 1 cycle per 16.
- Dig1=4'b1100 → slot 1 Seg=0111111 (dash). Dp_mask=0010 → Dp=0 only while slot 1 is displayed.
